// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//   Shares one system bus master port between the instruction fetch unit (IFU)
//   and the load/store unit (LSU). Each side issues single-cycle command
//   pulses. Commands are alignment-checked, latched as pending, and issued one
//   at a time as a single outstanding bus transaction. The LSU wins when both
//   sides are pending.
//
// Ports
//   clk, nrst          core clock, asynchronous active-low reset
//   i_ifu_*            fetch command (address + read pulse)
//   o_ifu_*            fetched word, busy (combinational stall), error flags
//   i_lsu_*            load/store command (address, write data, size, pulses)
//   o_lsu_*            load word (raw lanes), busy (combinational), error flags
//   o_bus_*            registered bus request: word address, wr, byte enables,
//                      write data; held stable while o_bus_req is high
//   i_bus_*            completion pulse with read data and error qualifier
// -----------------------------------------------------------------------------
module mem_arb (
  input  logic        clk,
  input  logic        nrst,
  // instruction fetch side
  input  logic [31:0] i_ifu_addr,
  input  logic        i_ifu_rd_cmd,
  output logic [31:0] o_ifu_instr_dat,
  output logic        o_ifu_busy,
  output logic        o_ifu_err_align,
  output logic        o_ifu_err_bus,
  // load/store side
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdat,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_rd_cmd,
  input  logic        i_lsu_wr_cmd,
  output logic [31:0] o_lsu_rdat,
  output logic        o_lsu_busy,
  output logic        o_lsu_err_align,
  output logic        o_lsu_err_bus,
  // system bus master port
  output logic [31:0] o_bus_addr,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdat,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdat,
  input  logic        i_bus_err
);

  localparam int unsigned CPU_ADDR_WIDTH = 32;
  localparam int unsigned CPU_DATA_WIDTH = 32;
  localparam int unsigned WORD_AW        = CPU_ADDR_WIDTH - 2;
  localparam int unsigned BE_WIDTH       = CPU_DATA_WIDTH / 8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_I = 2'd1,
    ST_BUS_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // pending request latches
  logic                      r_pend_i;
  logic [WORD_AW-1:0]        r_addr_i;
  logic                      r_pend_d;
  logic [CPU_ADDR_WIDTH-1:0] r_addr_d;
  logic [CPU_DATA_WIDTH-1:0] r_wdat_d;
  logic [1:0]                r_size_d;
  logic                      r_wr_d;

  // status registers
  logic [CPU_DATA_WIDTH-1:0] r_ifu_dat;
  logic                      r_ifu_err_align;
  logic                      r_ifu_err_bus;
  logic [CPU_DATA_WIDTH-1:0] r_lsu_dat;
  logic                      r_lsu_err_align;
  logic                      r_lsu_err_bus;

  // bus output registers
  logic [CPU_ADDR_WIDTH-1:0] r_bus_addr;
  logic                      r_bus_req;
  logic                      r_bus_wr;
  logic [BE_WIDTH-1:0]       r_bus_be;
  logic [CPU_DATA_WIDTH-1:0] r_bus_wdat;

  logic [CPU_ADDR_WIDTH-1:0] w_bus_addr_nxt;
  logic                      w_bus_req_nxt;
  logic                      w_bus_wr_nxt;
  logic [BE_WIDTH-1:0]       w_bus_be_nxt;
  logic [CPU_DATA_WIDTH-1:0] w_bus_wdat_nxt;

  logic w_issue_i;
  logic w_issue_d;
  logic w_arb;

  // byte enables for a naturally aligned access of the given size
  function automatic logic [BE_WIDTH-1:0] f_be(input logic [1:0] size,
                                                input logic [1:0] ofs);
    logic [BE_WIDTH-1:0] be;
    case (size)
      SZ_BYTE: be = BE_WIDTH'(4'b0001 << ofs);
      SZ_HALF: be = BE_WIDTH'(4'b0011 << ofs);
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // command qualification: a command while that side is busy is ignored
  logic w_ifu_act;
  logic w_ifu_cmd_ok;
  logic w_ifu_mis;
  logic w_ifu_cap;
  logic w_lsu_act;
  logic w_lsu_cmd;
  logic w_lsu_cmd_ok;
  logic w_lsu_mis;
  logic w_lsu_cap;

  assign w_ifu_act    = (r_state == ST_BUS_I);
  assign w_ifu_cmd_ok = i_ifu_rd_cmd & ~r_pend_i & ~w_ifu_act;
  assign w_ifu_mis    = |i_ifu_addr[1:0];
  assign w_ifu_cap    = w_ifu_cmd_ok & ~w_ifu_mis;

  assign w_lsu_act    = (r_state == ST_BUS_D);
  assign w_lsu_cmd    = i_lsu_rd_cmd | i_lsu_wr_cmd;
  assign w_lsu_cmd_ok = w_lsu_cmd & ~r_pend_d & ~w_lsu_act;
  assign w_lsu_cap    = w_lsu_cmd_ok & ~w_lsu_mis;

  // reserved size 3 is checked as a word
  always_comb begin
    w_lsu_mis = 1'b0;
    case (i_lsu_size)
      SZ_BYTE: w_lsu_mis = 1'b0;
      SZ_HALF: w_lsu_mis = i_lsu_addr[0];
      default: w_lsu_mis = |i_lsu_addr[1:0];
    endcase
  end

  // a command captured this edge can be issued on the same edge
  logic                      w_pend_i_eff;
  logic [WORD_AW-1:0]        w_addr_i_eff;
  logic                      w_pend_d_eff;
  logic [CPU_ADDR_WIDTH-1:0] w_addr_d_eff;
  logic [CPU_DATA_WIDTH-1:0] w_wdat_d_eff;
  logic [1:0]                w_size_d_eff;
  logic                      w_wr_d_eff;

  assign w_pend_i_eff = r_pend_i | w_ifu_cap;
  assign w_addr_i_eff = w_ifu_cap ? i_ifu_addr[CPU_ADDR_WIDTH-1:2] : r_addr_i;
  assign w_pend_d_eff = r_pend_d | w_lsu_cap;
  assign w_addr_d_eff = w_lsu_cap ? i_lsu_addr   : r_addr_d;
  assign w_wdat_d_eff = w_lsu_cap ? i_lsu_wdat   : r_wdat_d;
  assign w_size_d_eff = w_lsu_cap ? i_lsu_size   : r_size_d;
  assign w_wr_d_eff   = w_lsu_cap ? i_lsu_wr_cmd : r_wr_d;

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // arbitration (data side first) and next bus outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_issue_i      = 1'b0;
    w_issue_d      = 1'b0;
    w_arb          = 1'b0;
    w_bus_addr_nxt = r_bus_addr;
    w_bus_wr_nxt   = r_bus_wr;
    w_bus_be_nxt   = r_bus_be;
    w_bus_wdat_nxt = r_bus_wdat;

    case (r_state)
      ST_IDLE:            w_arb = 1'b1;
      ST_BUS_I, ST_BUS_D: w_arb = i_bus_ack;
      default:            w_arb = 1'b1;
    endcase

    if (w_arb) begin
      if (w_pend_d_eff) begin
        w_state_nxt = ST_BUS_D;
        w_issue_d   = 1'b1;
      end else if (w_pend_i_eff) begin
        w_state_nxt = ST_BUS_I;
        w_issue_i   = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end

    w_bus_req_nxt = (w_state_nxt != ST_IDLE);

    if (w_issue_d) begin
      w_bus_addr_nxt = {w_addr_d_eff[CPU_ADDR_WIDTH-1:2], 2'b00};
      w_bus_wr_nxt   = w_wr_d_eff;
      w_bus_be_nxt   = f_be(w_size_d_eff, w_addr_d_eff[1:0]);
      w_bus_wdat_nxt = w_wdat_d_eff;
    end else if (w_issue_i) begin
      w_bus_addr_nxt = {w_addr_i_eff, 2'b00};
      w_bus_wr_nxt   = 1'b0;
      w_bus_be_nxt   = '1;
      w_bus_wdat_nxt = '0;
    end
  end

  // bus output registers; only loaded on issue so they hold during a request
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bus_addr <= '0;
      r_bus_req  <= 1'b0;
      r_bus_wr   <= 1'b0;
      r_bus_be   <= '0;
      r_bus_wdat <= '0;
    end else begin
      r_bus_addr <= w_bus_addr_nxt;
      r_bus_req  <= w_bus_req_nxt;
      r_bus_wr   <= w_bus_wr_nxt;
      r_bus_be   <= w_bus_be_nxt;
      r_bus_wdat <= w_bus_wdat_nxt;
    end
  end

  // pending latches; issuing clears the flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pend_i <= 1'b0;
      r_addr_i <= '0;
      r_pend_d <= 1'b0;
      r_addr_d <= '0;
      r_wdat_d <= '0;
      r_size_d <= '0;
      r_wr_d   <= 1'b0;
    end else begin
      r_pend_i <= w_pend_i_eff & ~w_issue_i;
      r_pend_d <= w_pend_d_eff & ~w_issue_d;
      if (w_ifu_cap) begin
        r_addr_i <= i_ifu_addr[CPU_ADDR_WIDTH-1:2];
      end
      if (w_lsu_cap) begin
        r_addr_d <= i_lsu_addr;
        r_wdat_d <= i_lsu_wdat;
        r_size_d <= i_lsu_size;
        r_wr_d   <= i_lsu_wr_cmd;
      end
    end
  end

  // IFU status: errors reset on each accepted command, data holds otherwise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ifu_dat       <= '0;
      r_ifu_err_align <= 1'b0;
      r_ifu_err_bus   <= 1'b0;
    end else if (w_ifu_cmd_ok) begin
      r_ifu_err_align <= w_ifu_mis;
      r_ifu_err_bus   <= 1'b0;
    end else if (w_ifu_act && i_bus_ack) begin
      if (i_bus_err) begin
        r_ifu_err_bus <= 1'b1;
      end else begin
        r_ifu_dat <= i_bus_rdat;
      end
    end
  end

  // LSU status: writes never disturb the last load word
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lsu_dat       <= '0;
      r_lsu_err_align <= 1'b0;
      r_lsu_err_bus   <= 1'b0;
    end else if (w_lsu_cmd_ok) begin
      r_lsu_err_align <= w_lsu_mis;
      r_lsu_err_bus   <= 1'b0;
    end else if (w_lsu_act && i_bus_ack) begin
      if (i_bus_err) begin
        r_lsu_err_bus <= 1'b1;
      end else if (!r_bus_wr) begin
        r_lsu_dat <= i_bus_rdat;
      end
    end
  end

  // busy includes the command cycle itself so the pipeline stalls at once
  assign o_ifu_busy      = i_ifu_rd_cmd | r_pend_i | w_ifu_act;
  assign o_lsu_busy      = w_lsu_cmd | r_pend_d | w_lsu_act;

  assign o_ifu_instr_dat = r_ifu_dat;
  assign o_ifu_err_align = r_ifu_err_align;
  assign o_ifu_err_bus   = r_ifu_err_bus;
  assign o_lsu_rdat      = r_lsu_dat;
  assign o_lsu_err_align = r_lsu_err_align;
  assign o_lsu_err_bus   = r_lsu_err_bus;

  assign o_bus_addr      = r_bus_addr;
  assign o_bus_req       = r_bus_req;
  assign o_bus_wr        = r_bus_wr;
  assign o_bus_be        = r_bus_be;
  assign o_bus_wdat      = r_bus_wdat;

endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb: scenario-driven stimulus, bus responder and
// scoreboard monitor; expectations come from a transaction-level model.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] i_ifu_addr;
  logic        i_ifu_rd_cmd;
  logic [31:0] o_ifu_instr_dat;
  logic        o_ifu_busy;
  logic        o_ifu_err_align;
  logic        o_ifu_err_bus;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdat;
  logic [1:0]  i_lsu_size;
  logic        i_lsu_rd_cmd;
  logic        i_lsu_wr_cmd;
  logic [31:0] o_lsu_rdat;
  logic        o_lsu_busy;
  logic        o_lsu_err_align;
  logic        o_lsu_err_bus;
  logic [31:0] o_bus_addr;
  logic        o_bus_req;
  logic        o_bus_wr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdat;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdat;
  logic        i_bus_err;

  mem_arb dut (
    .clk(clk), .nrst(nrst),
    .i_ifu_addr(i_ifu_addr), .i_ifu_rd_cmd(i_ifu_rd_cmd),
    .o_ifu_instr_dat(o_ifu_instr_dat), .o_ifu_busy(o_ifu_busy),
    .o_ifu_err_align(o_ifu_err_align), .o_ifu_err_bus(o_ifu_err_bus),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wdat(i_lsu_wdat), .i_lsu_size(i_lsu_size),
    .i_lsu_rd_cmd(i_lsu_rd_cmd), .i_lsu_wr_cmd(i_lsu_wr_cmd),
    .o_lsu_rdat(o_lsu_rdat), .o_lsu_busy(o_lsu_busy),
    .o_lsu_err_align(o_lsu_err_align), .o_lsu_err_bus(o_lsu_err_bus),
    .o_bus_addr(o_bus_addr), .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr),
    .o_bus_be(o_bus_be), .o_bus_wdat(o_bus_wdat),
    .i_bus_ack(i_bus_ack), .i_bus_rdat(i_bus_rdat), .i_bus_err(i_bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdat;
    int          start;
    int          dly;
    logic [31:0] rdat;
    logic        err;
  } bus_t;

  typedef struct {
    logic [31:0] dat;
    logic        ea;
    logic        eb;
    int          done;
  } res_t;

  bus_t exp_bus[$];
  res_t exp_i[$];
  res_t exp_d[$];

  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_rdat  = 32'h0;

  bit in_txn    = 1'b0;
  bit ack_clr   = 1'b0;
  bit force_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // lanes covered by an access: sub-word sizes start at the byte offset
  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    int nb;
    int lo;
    be = 4'h0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lo = (nb == 4) ? 0 : int'(a);
    for (int n = 0; n < 4; n++)
      if (n >= lo && n < lo + nb) be[n] = 1'b1;
    return be;
  endfunction

  // bus responder plus scoreboard monitor, sampling on the falling edge
  initial begin
    bus_t cur;
    res_t r;
    int   s_act;
    logic prev_ib;
    logic prev_db;
    bit   ok;
    prev_ib = 1'b0;
    prev_db = 1'b0;
    s_act   = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        in_txn    = 1'b0;
        ack_clr   = 1'b0;
        i_bus_ack = 1'b0;
        i_bus_err = 1'b0;
      end else begin
        if (ack_clr) begin
          ack_clr   = 1'b0;
          in_txn    = 1'b0;
          i_bus_ack = 1'b0;
          i_bus_err = 1'b0;
        end
        if (in_txn) begin
          ok = (o_bus_req === 1'b1) && (o_bus_addr === cur.addr) &&
               (o_bus_wr === cur.wr) && (o_bus_be === cur.be) &&
               (!cur.wr || o_bus_wdat === cur.wdat);
          chk("bus_hold", 32'(ok), 32'd1);
        end else if (o_bus_req === 1'b1) begin
          if (exp_bus.size() == 0) begin
            chk("bus_unexpected_req", 32'(o_bus_req), 32'd0);
          end else begin
            cur = exp_bus.pop_front();
            chk("bus_start_cycle", 32'(cyc), 32'(cur.start));
            chk("bus_addr", o_bus_addr, cur.addr);
            chk("bus_wr", 32'(o_bus_wr), 32'(cur.wr));
            chk("bus_be", 32'(o_bus_be), 32'(cur.be));
            if (cur.wr) chk("bus_wdat", o_bus_wdat, cur.wdat);
            in_txn = 1'b1;
            s_act  = cyc;
          end
        end
        if (in_txn && cyc == s_act + cur.dly) begin
          i_bus_ack  = 1'b1;
          i_bus_rdat = cur.rdat;
          i_bus_err  = cur.err;
          ack_clr    = 1'b1;
        end else begin
          i_bus_ack  = force_ack && !in_txn;
          i_bus_err  = 1'b0;
          if (force_ack) i_bus_rdat = 32'hBAD0_BAD0;
        end

        if (prev_ib && !o_ifu_busy) begin
          if (exp_i.size() == 0) begin
            chk("ifu_unexpected_done", 32'(o_ifu_busy), 32'd1);
          end else begin
            r = exp_i.pop_front();
            chk("ifu_done_cycle", 32'(cyc), 32'(r.done));
            chk("ifu_instr_dat", o_ifu_instr_dat, r.dat);
            chk("ifu_err_align", 32'(o_ifu_err_align), 32'(r.ea));
            chk("ifu_err_bus", 32'(o_ifu_err_bus), 32'(r.eb));
          end
        end
        if (prev_db && !o_lsu_busy) begin
          if (exp_d.size() == 0) begin
            chk("lsu_unexpected_done", 32'(o_lsu_busy), 32'd1);
          end else begin
            r = exp_d.pop_front();
            chk("lsu_done_cycle", 32'(cyc), 32'(r.done));
            chk("lsu_rdat", o_lsu_rdat, r.dat);
            chk("lsu_err_align", 32'(o_lsu_err_align), 32'(r.ea));
            chk("lsu_err_bus", 32'(o_lsu_err_bus), 32'(r.eb));
          end
        end
      end
      prev_ib = o_ifu_busy;
      prev_db = o_lsu_busy;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_i.size() != 0 || exp_d.size() != 0 || exp_bus.size() != 0 || in_txn) && n < 80) begin
      sync();
      n++;
    end
    chk("drain_timeout", 32'(n < 80), 32'd1);
    if (n >= 80) begin
      exp_i.delete();
      exp_d.delete();
      exp_bus.delete();
    end
    sync();
  endtask

  // One scenario: optional IFU and LSU commands at offsets oi/od from now,
  // each with its bus response delay, read data and error.
  task automatic scn(input bit hi, input logic [31:0] ia, input int oi, input int di,
                     input logic [31:0] ird, input bit ierr,
                     input bit hd, input logic [31:0] da, input logic [31:0] dwd,
                     input logic [1:0] dsz, input bit dwr, input int od, input int dd,
                     input logic [31:0] drd, input bit derr);
    int   t, ti, td;
    bit   vi, vd, lmis;
    bus_t bi, bd;
    res_t ri, rd;
    t  = cyc;
    ti = t + oi;
    td = t + od;
    lmis = (dsz == 2'd1 && da[0]) || (dsz[1] && da[1:0] != 2'b00);
    vi = hi && (ia[1:0] == 2'b00);
    vd = hd && !lmis;

    bi.addr = {ia[31:2], 2'b00}; bi.wr = 1'b0; bi.be = 4'hF; bi.wdat = 32'h0;
    bi.dly = di; bi.rdat = ird; bi.err = ierr; bi.start = 0;
    bd.addr = {da[31:2], 2'b00}; bd.wr = dwr; bd.be = be_model(dsz, da[1:0]);
    bd.wdat = dwd; bd.dly = dd; bd.rdat = drd; bd.err = derr; bd.start = 0;

    if (vd && (!vi || td <= ti)) begin
      bd.start = td + 1;
      exp_bus.push_back(bd);
      if (vi) begin
        bi.start = imax(ti + 1, bd.start + dd + 1);
        exp_bus.push_back(bi);
      end
    end else if (vi) begin
      bi.start = ti + 1;
      exp_bus.push_back(bi);
      if (vd) begin
        bd.start = imax(td + 1, bi.start + di + 1);
        exp_bus.push_back(bd);
      end
    end

    if (hi) begin
      ri.done = vi ? bi.start + di + 1 : ti + 1;
      ri.ea   = !vi;
      ri.eb   = vi && ierr;
      if (vi && !ierr) m_instr = ird;
      ri.dat  = m_instr;
      exp_i.push_back(ri);
    end
    if (hd) begin
      rd.done = vd ? bd.start + dd + 1 : td + 1;
      rd.ea   = !vd;
      rd.eb   = vd && derr;
      if (vd && !derr && !dwr) m_rdat = drd;
      rd.dat  = m_rdat;
      exp_d.push_back(rd);
    end

    for (int k = 0; k < 3; k++) begin
      i_ifu_rd_cmd = hi && (oi == k);
      if (i_ifu_rd_cmd) i_ifu_addr = ia;
      i_lsu_rd_cmd = hd && (od == k) && !dwr;
      i_lsu_wr_cmd = hd && (od == k) && dwr;
      if (hd && od == k) begin
        i_lsu_addr = da;
        i_lsu_wdat = dwd;
        i_lsu_size = dsz;
      end
      sync();
    end
    i_ifu_rd_cmd = 1'b0;
    i_lsu_rd_cmd = 1'b0;
    i_lsu_wr_cmd = 1'b0;
    drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifu_dat"}, o_ifu_instr_dat, 32'h0);
    chk({tag, "_ifu_busy"}, 32'(o_ifu_busy), 32'd0);
    chk({tag, "_ifu_ea"}, 32'(o_ifu_err_align), 32'd0);
    chk({tag, "_ifu_eb"}, 32'(o_ifu_err_bus), 32'd0);
    chk({tag, "_lsu_rdat"}, o_lsu_rdat, 32'h0);
    chk({tag, "_lsu_busy"}, 32'(o_lsu_busy), 32'd0);
    chk({tag, "_lsu_ea"}, 32'(o_lsu_err_align), 32'd0);
    chk({tag, "_lsu_eb"}, 32'(o_lsu_err_bus), 32'd0);
    chk({tag, "_bus_addr"}, o_bus_addr, 32'h0);
    chk({tag, "_bus_req"}, 32'(o_bus_req), 32'd0);
    chk({tag, "_bus_wr"}, 32'(o_bus_wr), 32'd0);
    chk({tag, "_bus_be"}, 32'(o_bus_be), 32'd0);
    chk({tag, "_bus_wdat"}, o_bus_wdat, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_t hang;
    bit   hi, hd, dwr, ierr, derr;
    int   kind, oi, od, di, dd;
    logic [31:0] ia, da, dwd, ird, drd;
    logic [1:0]  sz;

    nrst = 1'b0;
    i_ifu_addr = 32'h0; i_ifu_rd_cmd = 1'b0;
    i_lsu_addr = 32'h0; i_lsu_wdat = 32'h0; i_lsu_size = 2'd0;
    i_lsu_rd_cmd = 1'b0; i_lsu_wr_cmd = 1'b0;
    i_bus_ack = 1'b0; i_bus_rdat = 32'h0; i_bus_err = 1'b0;
    repeat (3) sync();
    chk_all_zero("reset");
    nrst = 1'b1;
    sync();

    // directed cases from the usage notes
    scn(1, 32'h100, 0, 2, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 2'd0, 0, 0, 0, 32'h0, 0);
    scn(1, 32'h102, 0, 0, 32'h1111_1111, 0, 0, 32'h0, 32'h0, 2'd0, 0, 0, 0, 32'h0, 0);
    scn(1, 32'h104, 0, 0, 32'h1234_5678, 0, 0, 32'h0, 32'h0, 2'd0, 0, 0, 0, 32'h0, 0);
    scn(1, 32'h200, 0, 1, 32'hCAFE_0200, 0, 1, 32'h303, 32'hAA00_0000, 2'd0, 1, 0, 1, 32'h0, 0);
    scn(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h1001, 32'h0, 2'd1, 0, 0, 0, 32'h5555_AAAA, 0);
    scn(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h1002, 32'h0, 2'd1, 0, 0, 3, 32'h7777_8888, 1);
    scn(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h2000, 32'h0, 2'd2, 0, 0, 0, 32'h0BAD_F00D, 0);

    // randomized scenarios
    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 2);
      hi = (kind != 1);
      hd = (kind != 0);
      oi = 0;
      od = 0;
      if (hi && hd) begin
        if ($urandom_range(0, 1) == 1) oi = $urandom_range(0, 2);
        else od = $urandom_range(0, 2);
      end
      ia = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      da = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) da[0] = 1'b0;
        else if (sz[1]) da[1:0] = 2'b00;
      end
      dwr  = ($urandom_range(0, 1) == 1);
      dwd  = $urandom;
      ird  = $urandom;
      drd  = $urandom;
      ierr = ($urandom_range(0, 6) == 0);
      derr = ($urandom_range(0, 6) == 0);
      di   = $urandom_range(0, 3);
      dd   = $urandom_range(0, 3);
      scn(hi, ia, oi, di, ird, ierr, hd, da, dwd, sz, dwr, od, dd, drd, derr);
    end

    // reset while a data transaction is outstanding
    hang.addr = 32'h400; hang.wr = 1'b0; hang.be = 4'hF; hang.wdat = 32'h0;
    hang.start = cyc + 1; hang.dly = 1000; hang.rdat = 32'h0; hang.err = 1'b0;
    exp_bus.push_back(hang);
    i_lsu_addr = 32'h400; i_lsu_size = 2'd2; i_lsu_rd_cmd = 1'b1;
    sync();
    i_lsu_rd_cmd = 1'b0;
    sync();
    sync();
    chk("pre_reset_req", 32'(o_bus_req), 32'd1);
    chk("pre_reset_lsu_busy", 32'(o_lsu_busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_bus.delete();
    exp_i.delete();
    exp_d.delete();
    m_instr = 32'h0;
    m_rdat  = 32'h0;
    sync();
    sync();
    nrst = 1'b1;
    sync();

    // stray ack while idle must change nothing
    force_ack = 1'b1;
    sync();
    force_ack = 1'b0;
    sync();
    sync();
    chk_all_zero("stray_ack");

    // recovery after reset
    scn(1, 32'h800, 0, 1, 32'h600D_0800, 0, 1, 32'h900, 32'h0, 2'd2, 0, 1, 0, 32'h600D_0900, 0);
    chk("final_queue_empty", 32'(exp_bus.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
